// File: rtl/mem_programmer_ctrl_pkg.sv
// Shared encodings for the push-button memory programmer: operator commands
// and controller FSM states.
package mem_programmer_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_SET_ADRS = 2'b00,
        CMD_ENTER    = 2'b01,
        CMD_EXAMINE  = 2'b10,
        CMD_CLEAR    = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_WRITE   = 2'b01,
        S_RD_WAIT = 2'b10,
        S_RD_CAP  = 2'b11
    } state_e;

endpackage

// File: rtl/mem_programmer_ctrl_if.sv
// Program-mode port of the shared synchronous RAM. The controller drives
// address/data/strobe; the RAM returns read data one cycle after the address.
interface mem_programmer_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] mem_adrs;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_q;

    modport master (output mem_adrs, output mem_data, output mem_wr_en, input mem_q);
    modport slave  (input mem_adrs, input mem_data, input mem_wr_en, output mem_q);
endinterface

// File: rtl/mem_programmer_ctrl_button_debounce.sv
// Two-flop synchronizer plus stability counter for a mechanical button.
// Level flips after DEBOUNCE_CYC steady cycles; press_pulse marks a 0->1 flip.
module button_debounce #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press_pulse
);
    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync        <= 2'b00;
            level       <= 1'b0;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync        <= {sync[0], raw};
            press_pulse <= 1'b0;
            // any cycle agreeing with the current level restarts the count
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                level       <= sync[1];
                press_pulse <= sync[1];
                cnt         <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_programmer_ctrl.sv
// Push-button memory programmer: set address, chunked data entry with write,
// and read-back examine, driving the RAM program-mode port.
module mem_programmer_ctrl
    import mem_programmer_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int IN_W         = 8,
    parameter int DEBOUNCE_CYC = 16,
    parameter int AUTO_INC     = 1,
    localparam int NCHUNK      = DATA_W / IN_W,
    localparam int CW          = $clog2(NCHUNK) + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  p_button,
    input  logic [1:0]            cmd,
    input  logic [IN_W-1:0]       sw_in,
    mem_programmer_ctrl_if.master mem,
    output logic [ADDR_W-1:0]     cur_adrs,
    output logic [DATA_W-1:0]     cur_data,
    output logic [CW-1:0]         chunk_idx,
    output logic                  busy
);
    state_e            state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;
    logic              db_level;
    logic              db_pulse;
    logic              press;

    button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
        .clock       (clock),
        .reset       (reset),
        .raw         (p_button),
        .level       (db_level),
        .press_pulse (db_pulse)
    );

    assign press        = db_pulse & db_level;
    // MSB chunk arrives first; the shift also covers DATA_W == IN_W
    assign shreg_nxt    = (shreg << IN_W) | DATA_W'(sw_in);
    assign mem.mem_adrs = cur_adrs;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            shreg         <= '0;
            cur_adrs      <= '0;
            cur_data      <= '0;
            chunk_idx     <= '0;
            busy          <= 1'b0;
            mem.mem_data  <= '0;
            mem.mem_wr_en <= 1'b0;
        end else begin
            mem.mem_wr_en <= 1'b0;
            case (state)
                S_IDLE: if (press) begin
                    case (cmd_e'(cmd))
                        CMD_SET_ADRS: begin
                            cur_adrs  <= sw_in[ADDR_W-1:0];
                            chunk_idx <= '0;
                        end
                        CMD_ENTER: begin
                            shreg <= shreg_nxt;
                            if (chunk_idx == CW'(NCHUNK - 1)) begin
                                mem.mem_data  <= shreg_nxt;
                                cur_data      <= shreg_nxt;
                                chunk_idx     <= '0;
                                mem.mem_wr_en <= 1'b1;
                                busy          <= 1'b1;
                                state         <= S_WRITE;
                            end else begin
                                chunk_idx <= chunk_idx + 1'b1;
                            end
                        end
                        CMD_EXAMINE: begin
                            chunk_idx <= '0;
                            busy      <= 1'b1;
                            state     <= S_RD_WAIT;
                        end
                        CMD_CLEAR: begin
                            shreg     <= '0;
                            chunk_idx <= '0;
                        end
                    endcase
                end
                S_WRITE: begin
                    if (AUTO_INC != 0) cur_adrs <= cur_adrs + 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_RD_WAIT: state <= S_RD_CAP;
                S_RD_CAP: begin
                    cur_data <= mem.mem_q;
                    if (AUTO_INC != 0) cur_adrs <= cur_adrs + 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_programmer_ctrl.sv
// Directed bench: three controller variants (8-bit auto-inc, 16-bit data,
// 8-bit held address) share one button/switch bank, each with its own RAM.
module tb_mem_programmer_ctrl;
    import mem_programmer_ctrl_pkg::*;

    localparam int DB = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       p_button;
    logic [1:0] cmd;
    logic [7:0] sw_in;

    always #5 clock = ~clock;

    mem_programmer_ctrl_if #(.ADDR_W(8), .DATA_W(8))  ifa ();
    mem_programmer_ctrl_if #(.ADDR_W(8), .DATA_W(16)) ifb ();
    mem_programmer_ctrl_if #(.ADDR_W(8), .DATA_W(8))  ifc ();

    logic [7:0]  cur_adrs_a, cur_adrs_b, cur_adrs_c;
    logic [7:0]  cur_data_a, cur_data_c;
    logic [15:0] cur_data_b;
    logic        chunk_idx_a, chunk_idx_c;
    logic [1:0]  chunk_idx_b;
    logic        busy_a, busy_b, busy_c;
    logic        db_level, db_pulse;

    mem_programmer_ctrl #(.ADDR_W(8), .DATA_W(8), .IN_W(8), .DEBOUNCE_CYC(DB), .AUTO_INC(1)) dut_a (
        .clock(clock), .reset(reset), .p_button(p_button), .cmd(cmd), .sw_in(sw_in), .mem(ifa),
        .cur_adrs(cur_adrs_a), .cur_data(cur_data_a), .chunk_idx(chunk_idx_a), .busy(busy_a));
    mem_programmer_ctrl #(.ADDR_W(8), .DATA_W(16), .IN_W(8), .DEBOUNCE_CYC(DB), .AUTO_INC(1)) dut_b (
        .clock(clock), .reset(reset), .p_button(p_button), .cmd(cmd), .sw_in(sw_in), .mem(ifb),
        .cur_adrs(cur_adrs_b), .cur_data(cur_data_b), .chunk_idx(chunk_idx_b), .busy(busy_b));
    mem_programmer_ctrl #(.ADDR_W(8), .DATA_W(8), .IN_W(8), .DEBOUNCE_CYC(DB), .AUTO_INC(0)) dut_c (
        .clock(clock), .reset(reset), .p_button(p_button), .cmd(cmd), .sw_in(sw_in), .mem(ifc),
        .cur_adrs(cur_adrs_c), .cur_data(cur_data_c), .chunk_idx(chunk_idx_c), .busy(busy_c));
    button_debounce #(.DEBOUNCE_CYC(DB)) u_db (
        .clock(clock), .reset(reset), .raw(p_button), .level(db_level), .press_pulse(db_pulse));

    // RAM models: synchronous write, one-cycle registered read
    logic [7:0]  ram_a [256];
    logic [15:0] ram_b [256];
    logic [7:0]  ram_c [256];

    always @(posedge clock) begin
        if (ifa.mem_wr_en) ram_a[ifa.mem_adrs] <= ifa.mem_data;
        if (ifb.mem_wr_en) ram_b[ifb.mem_adrs] <= ifb.mem_data;
        if (ifc.mem_wr_en) ram_c[ifc.mem_adrs] <= ifc.mem_data;
        ifa.mem_q <= ram_a[ifa.mem_adrs];
        ifb.mem_q <= ram_b[ifb.mem_adrs];
        ifc.mem_q <= ram_c[ifc.mem_adrs];
    end

    // strobe log: one entry per cycle the strobe is high
    int          wr_cnt_a = 0, wr_cnt_b = 0;
    logic [7:0]  wr_adr_a = 0, wr_dat_a = 0, wr_adr_b = 0;
    logic [15:0] wr_dat_b = 0;

    always @(negedge clock) begin
        if (ifa.mem_wr_en) begin
            wr_cnt_a <= wr_cnt_a + 1; wr_adr_a <= ifa.mem_adrs; wr_dat_a <= ifa.mem_data;
        end
        if (ifb.mem_wr_en) begin
            wr_cnt_b <= wr_cnt_b + 1; wr_adr_b <= ifb.mem_adrs; wr_dat_b <= ifb.mem_data;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [1:0] c, input logic [7:0] s);
        @(negedge clock);
        cmd = c; sw_in = s; p_button = 1'b1;
        repeat (DB + 8) @(negedge clock);
        p_button = 1'b0;
        repeat (DB + 8) @(negedge clock);
    endtask

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] sw;
        logic [7:0] a_adrs, a_data;
        int         a_wr;
        logic [7:0] a_wadr, a_wdat, c_adrs, c_data;
    } vec_t;

    vec_t vt[9];

    initial begin
        int pulses, first, wa0, wb0;

        for (int i = 0; i < 256; i++) begin
            ram_a[i] = 8'h00; ram_b[i] = 16'h0000; ram_c[i] = 8'h00;
        end
        ram_a[8'h20] = 8'h5C;
        ram_c[8'h20] = 8'h5C;

        //            cmd           sw     A adrs data  wr  wadr   wdat   C adrs data
        vt[0] = '{CMD_SET_ADRS, 8'h10, 8'h10, 8'h00, 0, 8'h00, 8'h00, 8'h10, 8'h00};
        vt[1] = '{CMD_ENTER,    8'hA5, 8'h11, 8'hA5, 1, 8'h10, 8'hA5, 8'h10, 8'hA5};
        vt[2] = '{CMD_SET_ADRS, 8'h20, 8'h20, 8'hA5, 1, 8'h10, 8'hA5, 8'h20, 8'hA5};
        vt[3] = '{CMD_EXAMINE,  8'h00, 8'h21, 8'h5C, 1, 8'h10, 8'hA5, 8'h20, 8'h5C};
        vt[4] = '{CMD_SET_ADRS, 8'hFF, 8'hFF, 8'h5C, 1, 8'h10, 8'hA5, 8'hFF, 8'h5C};
        vt[5] = '{CMD_ENTER,    8'h01, 8'h00, 8'h01, 2, 8'hFF, 8'h01, 8'hFF, 8'h01};
        vt[6] = '{CMD_EXAMINE,  8'h00, 8'h01, 8'h00, 2, 8'hFF, 8'h01, 8'hFF, 8'h01};
        vt[7] = '{CMD_ENTER,    8'h3C, 8'h02, 8'h3C, 3, 8'h01, 8'h3C, 8'hFF, 8'h3C};
        vt[8] = '{CMD_CLEAR,    8'h77, 8'h02, 8'h3C, 3, 8'h01, 8'h3C, 8'hFF, 8'h3C};

        reset = 1'b1; p_button = 1'b0; cmd = CMD_CLEAR; sw_in = 8'h00;
        repeat (3) @(negedge clock);
        check("rst_adrs_a",  32'(cur_adrs_a), 32'h0);
        check("rst_data_a",  32'(cur_data_a), 32'h0);
        check("rst_mdata_a", 32'(ifa.mem_data), 32'h0);
        check("rst_wren_a",  32'(ifa.mem_wr_en), 32'h0);
        check("rst_chunk_b", 32'(chunk_idx_b), 32'h0);
        check("rst_busy_b",  32'(busy_b), 32'h0);
        check("rst_data_b",  32'(cur_data_b), 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // bouncing for 60 cycles must not produce a pulse
        pulses = 0;
        for (int t = 0; t < 12; t++) begin
            p_button = ~p_button;
            repeat (5) begin
                @(negedge clock);
                if (db_pulse) pulses++;
            end
        end
        check("bounce_no_pulse", 32'(pulses), 32'd0);
        p_button = 1'b1; pulses = 0; first = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clock);
            if (db_pulse) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        check("db_pulse_count", 32'(pulses), 32'd1);
        check("db_latency", 32'(first), 32'd18);
        check("db_level", 32'(db_level), 32'd1);
        p_button = 1'b0;
        repeat (DB + 8) @(negedge clock);

        for (int v = 0; v < 9; v++) begin
            press(vt[v].cmd, vt[v].sw);
            check($sformatf("v%0d_adrs_a", v), 32'(cur_adrs_a), 32'(vt[v].a_adrs));
            check($sformatf("v%0d_data_a", v), 32'(cur_data_a), 32'(vt[v].a_data));
            check($sformatf("v%0d_wrcnt_a", v), 32'(wr_cnt_a), 32'(vt[v].a_wr));
            check($sformatf("v%0d_wadr_a", v), 32'(wr_adr_a), 32'(vt[v].a_wadr));
            check($sformatf("v%0d_wdat_a", v), 32'(wr_dat_a), 32'(vt[v].a_wdat));
            check($sformatf("v%0d_adrs_c", v), 32'(cur_adrs_c), 32'(vt[v].c_adrs));
            check($sformatf("v%0d_data_c", v), 32'(cur_data_c), 32'(vt[v].c_data));
        end

        // examine timing: data captured at the third edge after the pulse edge
        press(CMD_SET_ADRS, 8'h20);
        @(negedge clock);
        cmd = CMD_EXAMINE; p_button = 1'b1;
        repeat (20) @(negedge clock);
        check("exam_busy_rdcap", 32'(busy_a), 32'd1);
        @(negedge clock);
        check("exam_data_a", 32'(cur_data_a), 32'h5C);
        check("exam_adrs_a", 32'(cur_adrs_a), 32'h21);
        check("exam_busy_done", 32'(busy_a), 32'd0);
        p_button = 1'b0;
        repeat (DB + 8) @(negedge clock);

        // multi-chunk entry on the 16-bit variant
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        wa0 = wr_cnt_a; wb0 = wr_cnt_b;
        press(CMD_ENTER, 8'h12);
        check("mc_chunk1_b", 32'(chunk_idx_b), 32'd1);
        check("mc_nowr_b", 32'(wr_cnt_b), 32'(wb0));
        check("single_chunk_a", 32'(chunk_idx_a), 32'd0);
        check("single_wr_a", 32'(wr_cnt_a), 32'(wa0 + 1));
        press(CMD_ENTER, 8'h34);
        check("mc_chunk0_b", 32'(chunk_idx_b), 32'd0);
        check("mc_wr_b", 32'(wr_cnt_b), 32'(wb0 + 1));
        check("mc_wadr_b", 32'(wr_adr_b), 32'h00);
        check("mc_wdat_b", 32'(wr_dat_b), 32'h1234);
        check("mc_data_b", 32'(cur_data_b), 32'h1234);
        check("mc_adrs_b", 32'(cur_adrs_b), 32'h01);

        // reset mid-entry discards the partial word
        press(CMD_ENTER, 8'hEE);
        check("rm_chunk_pre", 32'(chunk_idx_b), 32'd1);
        @(negedge clock); reset = 1'b1;
        #1;
        check("rm_chunk_b", 32'(chunk_idx_b), 32'd0);
        check("rm_adrs_b", 32'(cur_adrs_b), 32'h00);
        @(negedge clock); reset = 1'b0;
        wb0 = wr_cnt_b;
        press(CMD_ENTER, 8'hAB);
        check("rm_ab_nowr", 32'(wr_cnt_b), 32'(wb0));
        press(CMD_ENTER, 8'hCD);
        check("rm_wr_b", 32'(wr_cnt_b), 32'(wb0 + 1));
        check("rm_wadr_b", 32'(wr_adr_b), 32'h00);
        check("rm_wdat_b", 32'(wr_dat_b), 32'hABCD);
        check("rm_ram_b", 32'(ram_b[0]), 32'hABCD);

        // reset during WRITE kills the strobe at once and nothing follows
        @(negedge clock);
        cmd = CMD_ENTER; sw_in = 8'h99; p_button = 1'b1;
        repeat (19) @(negedge clock);
        check("wr_strobe_a", 32'(ifa.mem_wr_en), 32'd1);
        check("wr_strobe_adrs", 32'(ifa.mem_adrs), 32'h02);
        check("wr_strobe_data", 32'(ifa.mem_data), 32'h99);
        #1;
        wa0 = wr_cnt_a;
        reset = 1'b1;
        #1;
        check("wr_rst_kill", 32'(ifa.mem_wr_en), 32'd0);
        p_button = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (DB + 8) @(negedge clock);
        check("wr_rst_nomore", 32'(wr_cnt_a), 32'(wa0));
        check("wr_rst_busy", 32'(busy_a), 32'd0);
        check("wr_rst_adrs", 32'(cur_adrs_a), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
